// File: rtl/vga_paint_if.sv
// Paint-stroke write port and canvas-clear control between the paint tool and the renderer.
interface vga_paint_if;
    logic       paint_valid;
    logic       paint_ready;
    logic [7:0] paint_x;
    logic [6:0] paint_y;
    logic [2:0] paint_color;
    logic       clear_req;
    logic       clear_busy;

    modport master (
        output paint_valid, paint_x, paint_y, paint_color, clear_req,
        input  paint_ready, clear_busy
    );

    modport slave (
        input  paint_valid, paint_x, paint_y, paint_color, clear_req,
        output paint_ready, clear_busy
    );
endinterface

// File: rtl/vga_pixel_renderer.sv
// 160x120x3 paint framebuffer scanned out as 4x4-pixel cells, with cursor inversion,
// a paint write port and a clear sweep; RGB and syncs leave three cycles after sampling.
module vga_pixel_renderer #(
    parameter int         FB_W        = 160,
    parameter int         FB_H        = 120,
    parameter logic [2:0] CLEAR_COLOR = 3'd0
) (
    input  logic         pixel_clk_25,
    input  logic         reset,
    input  logic [9:0]   x_pos,
    input  logic [9:0]   y_pos,
    input  logic         vid_active,
    input  logic         hsync_in,
    input  logic         vsync_in,
    input  logic [7:0]   cursor_x,
    input  logic [6:0]   cursor_y,
    input  logic         cursor_en,
    vga_paint_if.slave   pif,
    output logic [3:0]   vga_r,
    output logic [3:0]   vga_g,
    output logic [3:0]   vga_b,
    output logic         vga_hsync,
    output logic         vga_vsync
);

    localparam int         FB_CELLS  = FB_W * FB_H;
    localparam logic [14:0] LAST_ADDR = 15'(FB_CELLS - 1);
    localparam logic [7:0] FB_W_C    = 8'(FB_W);
    localparam logic [6:0] FB_H_C    = 7'(FB_H);

    typedef enum logic {CLEAR, IDLE} wr_state_t;

    wr_state_t   state;
    logic [14:0] clear_addr;

    logic        we;
    logic [14:0] waddr;
    logic [2:0]  wdata;

    // Sub-cell pixel bits only select a position inside a 4x4 cell.
    logic unused_pix_bits;
    assign unused_pix_bits = ^{x_pos[1:0], y_pos[1:0]};

    // ---------------- write side ----------------
    logic paint_in_range;
    assign paint_in_range = (pif.paint_x < FB_W_C) && (pif.paint_y < FB_H_C);

    always_comb begin
        we    = 1'b0;
        waddr = clear_addr;
        wdata = CLEAR_COLOR;
        if (state == CLEAR) begin
            we = 1'b1;
        end else if (pif.paint_valid && paint_in_range) begin
            we    = 1'b1;
            waddr = 15'({pif.paint_y, 7'b0}) + 15'({pif.paint_y, 5'b0}) + 15'(pif.paint_x);
            wdata = pif.paint_color;
        end
    end

    always_ff @(posedge pixel_clk_25 or posedge reset) begin
        if (reset) begin
            state           <= CLEAR;
            clear_addr      <= '0;
            pif.clear_busy  <= 1'b1;
            pif.paint_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clear_addr == LAST_ADDR) begin
                        state           <= IDLE;
                        clear_addr      <= '0;
                        pif.clear_busy  <= 1'b0;
                        pif.paint_ready <= 1'b1;
                    end else begin
                        clear_addr <= clear_addr + 15'd1;
                    end
                end
                IDLE: begin
                    // A paint in the same cycle still lands; the sweep erases it later.
                    if (pif.clear_req) begin
                        state           <= CLEAR;
                        clear_addr      <= '0;
                        pif.clear_busy  <= 1'b1;
                        pif.paint_ready <= 1'b0;
                    end
                end
                default: begin
                    state           <= CLEAR;
                    clear_addr      <= '0;
                    pif.clear_busy  <= 1'b1;
                    pif.paint_ready <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- framebuffer ----------------
    logic [2:0]  fb_mem [FB_CELLS];
    logic [14:0] s1_addr;
    logic [2:0]  rd_data;

    // Read-first: non-blocking read sees the pre-write contents on a same-address collision.
    always_ff @(posedge pixel_clk_25) begin
        if (we) fb_mem[waddr] <= wdata;
        rd_data <= fb_mem[s1_addr];
    end

    // ---------------- read pipeline ----------------
    logic [7:0]  pix_col, pix_row;
    logic [14:0] rd_addr_c;
    logic        cursor_hit_c;

    assign pix_col      = x_pos[9:2];
    assign pix_row      = y_pos[9:2];
    assign rd_addr_c    = 15'({pix_row, 7'b0}) + 15'({pix_row, 5'b0}) + 15'(pix_col);
    assign cursor_hit_c = cursor_en && (pix_col == cursor_x) && (pix_row == {1'b0, cursor_y});

    // Index 0 is S1, index 1 is S2; S3 is the output register.
    logic [1:0] vld_pipe, hs_pipe, vs_pipe, cur_pipe;

    always_ff @(posedge pixel_clk_25 or posedge reset) begin
        if (reset) begin
            s1_addr  <= '0;
            vld_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            cur_pipe <= '0;
        end else begin
            s1_addr  <= vid_active ? rd_addr_c : 15'd0;
            vld_pipe <= {vld_pipe[0], vid_active};
            hs_pipe  <= {hs_pipe[0], hsync_in};
            vs_pipe  <= {vs_pipe[0], vsync_in};
            cur_pipe <= {cur_pipe[0], cursor_hit_c};
        end
    end

    function automatic logic [11:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 12'h000;
            3'd1:    palette = 12'hF00;
            3'd2:    palette = 12'h0F0;
            3'd3:    palette = 12'h00F;
            3'd4:    palette = 12'hFF0;
            3'd5:    palette = 12'h0FF;
            3'd6:    palette = 12'hF0F;
            default: palette = 12'hFFF;
        endcase
    endfunction

    logic [11:0] rgb_c;
    always_comb begin
        rgb_c = palette(rd_data);
        if (cur_pipe[1])  rgb_c = rgb_c ^ 12'hFFF;
        if (!vld_pipe[1]) rgb_c = 12'h000;
    end

    always_ff @(posedge pixel_clk_25 or posedge reset) begin
        if (reset) begin
            {vga_r, vga_g, vga_b} <= 12'h000;
            vga_hsync             <= 1'b1;
            vga_vsync             <= 1'b1;
        end else begin
            {vga_r, vga_g, vga_b} <= rgb_c;
            vga_hsync             <= hs_pipe[1];
            vga_vsync             <= vs_pipe[1];
        end
    end

endmodule
